// File: rtl/fft_sdf_stage.sv
// Radix-2 DIF single-path delay-feedback FFT stage with a DELAY-deep feedback line.
// Emits butterfly sums directly and recirculated differences with their W16 twiddle.
module fft_sdf_stage #(
  parameter int DELAY = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic signed [15:0] Re_in,
  input  logic signed [15:0] Im_in,
  output logic               out_valid,
  output logic signed [15:0] Re_out,
  output logic signed [15:0] Im_out,
  output logic signed [11:0] Re_tw,
  output logic signed [11:0] Im_tw
);

  localparam int CW    = $clog2(2 * DELAY);
  localparam int KSTEP = 8 / DELAY;

  logic [CW-1:0]      r_cnt;
  logic               r_primed;
  logic signed [15:0] r_dl_re [DELAY];
  logic signed [15:0] r_dl_im [DELAY];

  logic               w_fill;
  logic signed [15:0] w_pop_re, w_pop_im;
  logic signed [16:0] w_sum_re, w_sum_im, w_dif_re, w_dif_im;
  logic signed [15:0] w_out_re, w_out_im, w_push_re, w_push_im;
  logic [2:0]         w_k;
  logic [23:0]        w_tw;

  // W16^k scaled by 1024, packed as {re, im}.
  function automatic logic [23:0] tw_lookup(input logic [2:0] k);
    logic [23:0] t;
    case (k)
      3'd0:    t = {12'sd1024, 12'sd0};
      3'd1:    t = {12'sd946, -12'sd392};
      3'd2:    t = {12'sd724, -12'sd724};
      3'd3:    t = {12'sd392, -12'sd946};
      3'd4:    t = {12'sd0, -12'sd1024};
      3'd5:    t = {-12'sd392, -12'sd946};
      3'd6:    t = {-12'sd724, -12'sd724};
      3'd7:    t = {-12'sd946, -12'sd392};
      default: t = {12'sd1024, 12'sd0};
    endcase
    return t;
  endfunction

  // 2*DELAY is a power of two, so the counter MSB alone marks the butterfly half.
  assign w_fill   = ~r_cnt[CW-1];
  assign w_pop_re = r_dl_re[DELAY-1];
  assign w_pop_im = r_dl_im[DELAY-1];
  assign w_sum_re = {w_pop_re[15], w_pop_re} + {Re_in[15], Re_in};
  assign w_sum_im = {w_pop_im[15], w_pop_im} + {Im_in[15], Im_in};
  assign w_dif_re = {w_pop_re[15], w_pop_re} - {Re_in[15], Re_in};
  assign w_dif_im = {w_pop_im[15], w_pop_im} - {Im_in[15], Im_in};

  // Select output, feedback value and twiddle index for the current phase.
  always_comb begin
    w_out_re  = w_pop_re;
    w_out_im  = w_pop_im;
    w_push_re = Re_in;
    w_push_im = Im_in;
    w_k       = 3'd0;
    if (w_fill) begin
      w_out_re  = w_pop_re;
      w_out_im  = w_pop_im;
      w_push_re = Re_in;
      w_push_im = Im_in;
      w_k       = 3'(int'(r_cnt) * KSTEP);
    end else begin
      w_out_re  = w_sum_re[16:1];
      w_out_im  = w_sum_im[16:1];
      w_push_re = w_dif_re[16:1];
      w_push_im = w_dif_im[16:1];
      w_k       = 3'd0;
    end
  end

  assign w_tw = tw_lookup(w_k);

  // Frame counter and primed flag; primed rises on the first wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_primed <= 1'b0;
    end else if (in_valid) begin
      r_cnt <= r_cnt + CW'(1);
      if (&r_cnt) begin
        r_primed <= 1'b1;
      end else begin
        r_primed <= r_primed;
      end
    end else begin
      r_cnt    <= r_cnt;
      r_primed <= r_primed;
    end
  end

  // Feedback delay line, shifted once per accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        r_dl_re[i] <= 16'sd0;
        r_dl_im[i] <= 16'sd0;
      end
    end else if (in_valid) begin
      r_dl_re[0] <= w_push_re;
      r_dl_im[0] <= w_push_im;
      for (int i = 1; i < DELAY; i++) begin
        r_dl_re[i] <= r_dl_re[i-1];
        r_dl_im[i] <= r_dl_im[i-1];
      end
    end else begin
      for (int i = 0; i < DELAY; i++) begin
        r_dl_re[i] <= r_dl_re[i];
        r_dl_im[i] <= r_dl_im[i];
      end
    end
  end

  // Registered outputs; data and twiddle hold while idle, valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Re_out    <= 16'sd0;
      Im_out    <= 16'sd0;
      Re_tw     <= 12'sd1024;
      Im_tw     <= 12'sd0;
    end else if (in_valid) begin
      out_valid <= ~w_fill | r_primed;
      Re_out    <= w_out_re;
      Im_out    <= w_out_im;
      Re_tw     <= w_tw[23:12];
      Im_tw     <= w_tw[11:0];
    end else begin
      out_valid <= 1'b0;
      Re_out    <= Re_out;
      Im_out    <= Im_out;
      Re_tw     <= Re_tw;
      Im_tw     <= Im_tw;
    end
  end

endmodule

// File: tb/tb_fft_sdf_stage.sv
// Directed bench for fft_sdf_stage at DELAY = 8, 1 and 4 with hand-derived expectations.
module tb_fft_sdf_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               v8 = 1'b0, v1 = 1'b0, v4 = 1'b0;
  logic signed [15:0] re8 = '0, im8 = '0, re1 = '0, im1 = '0, re4 = '0, im4 = '0;
  logic               o8_v, o1_v, o4_v;
  logic signed [15:0] o8_re, o8_im, o1_re, o1_im, o4_re, o4_im;
  logic signed [11:0] o8_twr, o8_twi, o1_twr, o1_twi, o4_twr, o4_twi;

  int n_checks = 0;
  int n_errors = 0;

  int tw_re [8] = '{1024, 946, 724, 392, 0, -392, -724, -946};
  int tw_im [8] = '{0, -392, -724, -946, -1024, -946, -724, -392};

  fft_sdf_stage #(.DELAY(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .Re_in(re8), .Im_in(im8),
    .out_valid(o8_v), .Re_out(o8_re), .Im_out(o8_im), .Re_tw(o8_twr), .Im_tw(o8_twi)
  );
  fft_sdf_stage #(.DELAY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .Re_in(re1), .Im_in(im1),
    .out_valid(o1_v), .Re_out(o1_re), .Im_out(o1_im), .Re_tw(o1_twr), .Im_tw(o1_twi)
  );
  fft_sdf_stage #(.DELAY(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4), .Re_in(re4), .Im_in(im4),
    .out_valid(o4_v), .Re_out(o4_re), .Im_out(o4_im), .Re_tw(o4_twr), .Im_tw(o4_twi)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input int v, input int re, input int im,
                      input int twr, input int twi);
    chk({tag, ".v"}, int'(o8_v), v);
    chk({tag, ".re"}, int'(o8_re), re);
    chk({tag, ".im"}, int'(o8_im), im);
    chk({tag, ".twr"}, int'(o8_twr), twr);
    chk({tag, ".twi"}, int'(o8_twi), twi);
  endtask

  // Unprimed frame of Re=2n: silent fill, then sums 2n-8 with unit twiddle.
  task automatic frame8_first(input string tag);
    for (int n = 0; n < 16; n++) begin
      v8 = 1'b1; re8 = 16'(2 * n); im8 = 16'sd0;
      step();
      if (n < 8) chk({tag, ".fillv"}, int'(o8_v), 0);
      else       chk8({tag, ".bfly"}, 1, 2 * n - 8, 0, 1024, 0);
    end
    v8 = 1'b0;
  endtask

  // Primed frame of Re=2n, optionally with an idle cycle after every sample.
  task automatic frame8_primed(input string tag, input bit gaps);
    for (int n = 0; n < 16; n++) begin
      v8 = 1'b1; re8 = 16'(2 * n); im8 = 16'sd0;
      step();
      if (n < 8) chk8({tag, ".fill"}, 1, -8, 0, tw_re[n], tw_im[n]);
      else       chk8({tag, ".bfly"}, 1, 2 * n - 8, 0, 1024, 0);
      if (gaps) begin
        v8 = 1'b0; re8 = 16'sd999;
        step();
        chk({tag, ".idlev"}, int'(o8_v), 0);
        chk({tag, ".idlehold"}, int'(o8_re), (n < 8) ? -8 : 2 * n - 8);
      end
    end
    v8 = 1'b0;
  endtask

  initial begin
    #12;
    chk8("rst", 0, 0, 0, 1024, 0);
    rst_n = 1'b1;

    frame8_first("f1");
    frame8_primed("f2", 1'b0);
    v8 = 1'b0;
    step();
    chk("idle.v", int'(o8_v), 0);
    chk("idle.hold", int'(o8_re), 22);

    for (int n = 0; n < 5; n++) begin
      v8 = 1'b1; re8 = 16'(2 * n); im8 = 16'sd0;
      step();
    end
    v8 = 1'b0;
    rst_n = 1'b0;
    #1;
    chk8("midrst", 0, 0, 0, 1024, 0);
    step();
    rst_n = 1'b1;
    frame8_first("post");
    frame8_primed("tog", 1'b1);

    v1 = 1'b1; re1 = -16'sd3; im1 = 16'sd0;
    step();
    chk("d1.fillv", int'(o1_v), 0);
    re1 = 16'sd0; im1 = 16'sd5;
    step();
    chk("d1.bv", int'(o1_v), 1);
    chk("d1.bre", int'(o1_re), -2);
    chk("d1.bim", int'(o1_im), 2);
    chk("d1.btwr", int'(o1_twr), 1024);
    re1 = 16'sd0; im1 = 16'sd0;
    step();
    chk("d1.fv", int'(o1_v), 1);
    chk("d1.fre", int'(o1_re), -2);
    chk("d1.fim", int'(o1_im), -3);
    chk("d1.ftwr", int'(o1_twr), 1024);
    chk("d1.ftwi", int'(o1_twi), 0);
    v1 = 1'b0;

    for (int n = 0; n < 8; n++) begin
      v4 = 1'b1; re4 = 16'(4 * n); im4 = 16'sd0;
      step();
      if (n < 4) chk("d4.f1v", int'(o4_v), 0);
      else begin
        chk("d4.bv", int'(o4_v), 1);
        chk("d4.bre", int'(o4_re), 4 * n - 8);
      end
    end
    for (int n = 0; n < 4; n++) begin
      re4 = 16'sd7; im4 = 16'sd0;
      step();
      chk("d4.f2v", int'(o4_v), 1);
      chk("d4.f2re", int'(o4_re), -8);
      chk("d4.f2im", int'(o4_im), 0);
      chk("d4.f2twr", int'(o4_twr), tw_re[2 * n]);
      chk("d4.f2twi", int'(o4_twi), tw_im[2 * n]);
    end
    v4 = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fft_sdf_stage.md
FFT_SDF_STAGE -- requirements
Module: fft_sdf_stage

Interface
REQ-001 SHALL have parameter DELAY, default 8, meaning the delay-line depth; legal values are 1, 2, 4 and 8, giving a butterfly span of 2*DELAY points.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset is asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1 bit: an input sample is presented this cycle.
REQ-005 SHALL have ports Re_in and Im_in, input, signed 16 bits each: the input sample.
REQ-006 SHALL have port out_valid, output, 1 bit: the output sample and twiddle are valid.
REQ-007 SHALL have ports Re_out and Im_out, output, signed 16 bits each: the butterfly output, which feeds the downstream complex multiplier data inputs.
REQ-008 SHALL have ports Re_tw and Im_tw, output, signed 12 bits each: the twiddle in Q1.10 format (1.0 = 1024), aligned with Re_out/Im_out.

Function
REQ-009 SHALL implement one radix-2 DIF single-path-delay-feedback stage, with a DELAY-deep complex delay line of 16+16 bits per entry.
REQ-010 SHALL keep counter cnt, modulo 2*DELAY, that advances only on cycles with in_valid=1.
REQ-011 SHALL hold all state (cnt, delay line, outputs except out_valid) when in_valid=0, and SHALL drive out_valid=0 on the next cycle.
REQ-012 In the fill phase (cnt < DELAY), for each accepted sample x the block SHALL:
  - push x into the delay line;
  - output the popped entry d;
  - drive twiddle index k = cnt*(8/DELAY).
REQ-013 In the butterfly phase (cnt >= DELAY), with d = popped entry and x = input, the block SHALL:
  - output (d + x) >>> 1 with twiddle index 0;
  - push (d - x) >>> 1 into the delay line.
REQ-014 Butterfly arithmetic SHALL use a 17-bit signed intermediate, followed by an arithmetic shift right by 1 (floor; no rounding, no saturation), on Re and Im independently.
REQ-015 The twiddle for index k SHALL be W16^k = cos(2*pi*k/16) - j*sin(2*pi*k/16), scaled by 1024 and rounded, from a constant table:
  - k=0: (1024, 0)
  - k=1: (946, -392)
  - k=2: (724, -724)
  - k=3: (392, -946)
  - k=4: (0, -1024)
  - k=5: (-392, -946)
  - k=6: (-724, -724)
  - k=7: (-946, -392)
REQ-016 Outputs SHALL be registered: the result for a sample accepted in cycle t appears with out_valid=1 in cycle t+1 (latency 1).
REQ-017 SHALL keep a primed flag, set when cnt first wraps from 2*DELAY-1 to 0; while primed=0, fill-phase outputs SHALL have out_valid=0 (delay-line contents are not yet meaningful).
REQ-018 Butterfly-phase outputs SHALL always assert out_valid, including in the first frame.
REQ-019 When in_valid=1 at cnt=2*DELAY-1, cnt SHALL wrap to 0 in the same cycle, and the next frame's fill phase SHALL output the previous frame's differences.
REQ-020 With DELAY=1, the delay line is a single register and the fill-phase twiddle index SHALL be 0.

Reset
REQ-021 While rst_n=0 (asynchronously on assertion), the block SHALL clear:
  - cnt and primed to 0;
  - all delay-line entries to 0;
  - out_valid, Re_out, Im_out and Im_tw to 0;
  - and SHALL set Re_tw to 1024.
REQ-022 A reset mid-frame SHALL discard the partial frame; the first sample after release SHALL be treated as cnt=0 of a new, unprimed frame.

Verification
REQ-023 DELAY=8, continuous in_valid, Re_in=2n, Im_in=0 for n=0..15 -> no out_valid for n=0..7; then outputs Re=2n+8 (n=0..7), Im=0, tw=(1024,0), each one cycle after input n+8.
REQ-024 Same stream, then a second frame -> its first 8 outputs are Re=-8, Im=0, with tw index k=0..7 matching the REQ-015 table.
REQ-025 Odd/negative rounding, DELAY=1, inputs (-3,0) then (0,5) -> butterfly output Re=-2, Im=2; pushed difference Re=-2, Im=-3, visible on the next fill-phase output.
REQ-026 in_valid toggling 1,0,1,0 over a full frame -> results identical to the continuous case; out_valid=0 in every cycle following in_valid=0.
REQ-027 rst_n pulsed low after 5 samples of a frame -> outputs zero, Re_tw=1024 and out_valid=0 immediately; the next 16 samples behave exactly as REQ-023.
REQ-028 DELAY=4 frame followed by a second frame -> fill-phase twiddle indices are 0, 2, 4, 6.
